// File: rtl/washer_ctrl_param_if.sv
// Washer controller bundle: operator/sensor inputs and actuator/status outputs.
// No latency of its own; pure wiring between the controller and its environment.
// No backpressure: level signals sampled every clock by the controller.
interface washer_ctrl_param_if #(
    parameter int TIMER_W = 8
);
    logic               power;
    logic               doorclosed;
    logic               soap;
    logic               start;
    logic [2:0]         program_selection;
    logic               valve_in_cold;
    logic               valve_in_hot;
    logic               valve_out;
    logic               motor;
    logic [TIMER_W-1:0] timer_display;
    logic               program_done;
    logic               soap_warning;
    logic [3:0]         phase;

    // Environment side: drives the machine inputs, observes the outputs.
    modport master (
        output power, doorclosed, soap, start, program_selection,
        input  valve_in_cold, valve_in_hot, valve_out, motor,
        input  timer_display, program_done, soap_warning, phase
    );

    // Controller side.
    modport slave (
        input  power, doorclosed, soap, start, program_selection,
        output valve_in_cold, valve_in_hot, valve_out, motor,
        output timer_display, program_done, soap_warning, phase
    );
endinterface

// File: rtl/washer_ctrl_param.sv
// Washing-machine sequencer: soap wait, fill, wash, drain, N rinses, spin, done; door pause; power abort.
// Latency: all outputs are registered and reflect the state entered at the most recent clock edge.
// No backpressure: inputs are levels sampled every edge; a phase of duration N holds for exactly N cycles.
module washer_ctrl_param #(
    parameter int TIMER_W = 8,
    parameter int FILL_T  = 10,
    parameter int WASH_T  = 20,
    parameter int DRAIN_T = 8,
    parameter int RINSE_T = 15,
    parameter int SPIN_T  = 12,
    parameter int SOAP_TO = 50,
    parameter int RINSE_N = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    washer_ctrl_param_if.slave   bus
);

    typedef enum logic [3:0] {
        S_IDLE        = 4'd0,
        S_SOAP_WAIT   = 4'd1,
        S_FILL        = 4'd2,
        S_WASH        = 4'd3,
        S_DRAIN       = 4'd4,
        S_RINSE_FILL  = 4'd5,
        S_RINSE       = 4'd6,
        S_RINSE_DRAIN = 4'd7,
        S_SPIN        = 4'd8,
        S_DONE        = 4'd9,
        S_PAUSE       = 4'd10
    } state_t;

    localparam logic [TIMER_W-1:0] C_FILL  = TIMER_W'(FILL_T);
    localparam logic [TIMER_W-1:0] C_WASH  = TIMER_W'(WASH_T);
    localparam logic [TIMER_W-1:0] C_DRAIN = TIMER_W'(DRAIN_T);
    localparam logic [TIMER_W-1:0] C_RINSE = TIMER_W'(RINSE_T);
    localparam logic [TIMER_W-1:0] C_SPIN  = TIMER_W'(SPIN_T);
    localparam logic [TIMER_W-1:0] C_SOAP  = TIMER_W'(SOAP_TO);
    localparam logic [TIMER_W-1:0] C_ONE   = TIMER_W'(1);
    localparam logic [3:0]         C_RN    = 4'(RINSE_N);

    state_t             r_state, r_saved, w_state, w_saved;
    logic [TIMER_W-1:0] r_cnt, w_cnt;
    logic [3:0]         r_rinse, w_rinse;
    logic               r_hot_prog, w_hot_prog;
    logic               r_cold, r_hot, r_vout, r_motor, r_done, r_soapw;
    logic               w_last;
    logic [TIMER_W-1:0] w_dec;

    assign w_last = (r_cnt == C_ONE);
    assign w_dec  = r_cnt - C_ONE;

    // Next-state, phase counter, rinse counter and pause bookkeeping.
    always_comb begin
        w_state    = r_state;
        w_saved    = r_saved;
        w_cnt      = r_cnt;
        w_rinse    = r_rinse;
        w_hot_prog = r_hot_prog;
        if (!bus.power) begin
            // Power loss wins over everything, including an open door.
            w_state = S_IDLE;
            w_saved = S_IDLE;
            w_cnt   = '0;
            w_rinse = '0;
        end else if (!bus.doorclosed && r_state != S_IDLE &&
                     r_state != S_DONE && r_state != S_PAUSE) begin
            // Freeze counters; remember where to come back to.
            w_saved = r_state;
            w_state = S_PAUSE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    w_cnt   = '0;
                    w_rinse = '0;
                    if (bus.start && bus.doorclosed && !bus.program_selection[2]) begin
                        w_hot_prog = (bus.program_selection[1:0] == 2'b01);
                        case (bus.program_selection[1:0])
                            2'b00, 2'b01: begin
                                w_state = bus.soap ? S_FILL : S_SOAP_WAIT;
                                w_cnt   = bus.soap ? C_FILL : C_SOAP;
                            end
                            2'b10: begin
                                w_state = S_RINSE_FILL;
                                w_cnt   = C_FILL;
                            end
                            default: begin
                                w_state = S_SPIN;
                                w_cnt   = C_SPIN;
                            end
                        endcase
                    end
                end
                S_SOAP_WAIT: begin
                    if (bus.soap) begin
                        w_state = S_FILL;
                        w_cnt   = C_FILL;
                    end else if (w_last) begin
                        // Timed out waiting for detergent: abort without done.
                        w_state = S_IDLE;
                        w_cnt   = '0;
                    end else begin
                        w_cnt = w_dec;
                    end
                end
                S_FILL: begin
                    if (w_last) begin w_state = S_WASH; w_cnt = C_WASH; end
                    else w_cnt = w_dec;
                end
                S_WASH: begin
                    if (w_last) begin w_state = S_DRAIN; w_cnt = C_DRAIN; end
                    else w_cnt = w_dec;
                end
                S_DRAIN: begin
                    if (w_last) begin w_state = S_RINSE_FILL; w_cnt = C_FILL; end
                    else w_cnt = w_dec;
                end
                S_RINSE_FILL: begin
                    if (w_last) begin w_state = S_RINSE; w_cnt = C_RINSE; end
                    else w_cnt = w_dec;
                end
                S_RINSE: begin
                    if (w_last) begin w_state = S_RINSE_DRAIN; w_cnt = C_DRAIN; end
                    else w_cnt = w_dec;
                end
                S_RINSE_DRAIN: begin
                    if (w_last) begin
                        w_rinse = r_rinse + 4'd1;
                        if (r_rinse + 4'd1 == C_RN) begin
                            w_state = S_SPIN;
                            w_cnt   = C_SPIN;
                        end else begin
                            w_state = S_RINSE_FILL;
                            w_cnt   = C_FILL;
                        end
                    end else begin
                        w_cnt = w_dec;
                    end
                end
                S_SPIN: begin
                    if (w_last) begin w_state = S_DONE; w_cnt = '0; end
                    else w_cnt = w_dec;
                end
                S_DONE: begin
                    w_state = S_IDLE;
                    w_cnt   = '0;
                    w_rinse = '0;
                end
                S_PAUSE: begin
                    // Resume exactly where we stopped; the counter is not reloaded.
                    if (bus.doorclosed) w_state = r_saved;
                end
                default: begin
                    w_state = S_IDLE;
                    w_cnt   = '0;
                    w_rinse = '0;
                end
            endcase
        end
    end

    // State register with Moore outputs registered from the next state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_saved    <= S_IDLE;
            r_cnt      <= '0;
            r_rinse    <= '0;
            r_hot_prog <= 1'b0;
            r_cold     <= 1'b0;
            r_hot      <= 1'b0;
            r_vout     <= 1'b0;
            r_motor    <= 1'b0;
            r_done     <= 1'b0;
            r_soapw    <= 1'b0;
        end else begin
            r_state    <= w_state;
            r_saved    <= w_saved;
            r_cnt      <= w_cnt;
            r_rinse    <= w_rinse;
            r_hot_prog <= w_hot_prog;
            r_cold     <= (w_state == S_FILL && !w_hot_prog) || (w_state == S_RINSE_FILL);
            r_hot      <= (w_state == S_FILL && w_hot_prog);
            r_vout     <= (w_state == S_DRAIN) || (w_state == S_RINSE_DRAIN) || (w_state == S_SPIN);
            r_motor    <= (w_state == S_WASH) || (w_state == S_RINSE) || (w_state == S_SPIN);
            r_done     <= (w_state == S_DONE);
            r_soapw    <= (w_state == S_SOAP_WAIT) ||
                          (w_state == S_PAUSE && w_saved == S_SOAP_WAIT);
        end
    end

    assign bus.valve_in_cold = r_cold;
    assign bus.valve_in_hot  = r_hot;
    assign bus.valve_out     = r_vout;
    assign bus.motor         = r_motor;
    assign bus.timer_display = r_cnt;
    assign bus.program_done  = r_done;
    assign bus.soap_warning  = r_soapw;
    assign bus.phase         = r_state;

endmodule

// File: tb/tb_washer_ctrl_param.sv
// Bench for washer_ctrl_param: per-cycle expected trace queued at stimulus time, popped each cycle.
// Latency: one entry per clock, observed at the falling edge after each rising edge.
// Inputs driven at the falling edge so they are stable for the next rising edge.
module tb_washer_ctrl_param;

    typedef struct packed {
        logic [3:0] ph;
        logic [7:0] disp;
        logic [5:0] act;   // cold, hot, out, motor, done, soap_warning
    } exp_t;

    localparam logic [5:0] A_NONE = 6'b000000;
    localparam logic [5:0] A_COLD = 6'b100000;
    localparam logic [5:0] A_HOT  = 6'b010000;
    localparam logic [5:0] A_OUT  = 6'b001000;
    localparam logic [5:0] A_MOT  = 6'b000100;
    localparam logic [5:0] A_DONE = 6'b000010;
    localparam logic [5:0] A_SW   = 6'b000001;
    localparam logic [5:0] A_SPIN = 6'b001100;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_vec  = 0;
    int   n_miss = 0;
    exp_t sb[$];

    washer_ctrl_param_if #(.TIMER_W(8)) bus ();

    washer_ctrl_param dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    function automatic exp_t obs();
        return {bus.phase, bus.timer_display, bus.valve_in_cold, bus.valve_in_hot,
                bus.valve_out, bus.motor, bus.program_done, bus.soap_warning};
    endfunction

    task automatic push_phase(input logic [3:0] ph, input int n, input logic [5:0] a);
        for (int d = n; d >= 1; d--) sb.push_back({ph, 8'(d), a});
    endtask

    task automatic push_hold(input logic [3:0] ph, input int disp, input int k, input logic [5:0] a);
        for (int j = 0; j < k; j++) sb.push_back({ph, 8'(disp), a});
    endtask

    task automatic push_rinses_spin_done();
        for (int r = 0; r < 2; r++) begin
            push_phase(4'd5, 10, A_COLD);
            push_phase(4'd6, 15, A_MOT);
            push_phase(4'd7, 8, A_OUT);
        end
        push_phase(4'd8, 12, A_SPIN);
        push_hold(4'd9, 0, 1, A_DONE);
        push_hold(4'd0, 0, 2, A_NONE);
    endtask

    task automatic test_reset();
        exp_t o;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            o = obs();
            n_vec++;
            if (o !== exp_t'(0)) begin
                n_miss++;
                $display("FAIL reset k=%0d got %h want 0", k, o);
            end
        end
        rst = 1'b0;
        push_hold(4'd0, 0, 2, A_NONE);
        while (sb.size() != 0) begin
            exp_t e;
            @(negedge clk);
            e = sb.pop_front(); o = obs(); n_vec++;
            if (o !== e) begin
                n_miss++;
                $display("FAIL reset_idle got ph=%0d disp=%0d act=%b want ph=%0d disp=%0d act=%b",
                         o.ph, o.disp, o.act, e.ph, e.disp, e.act);
            end
        end
    endtask

    task automatic test_cold_wash();
        int i = 0;
        int done_at = -1;
        exp_t e, o;
        bus.soap = 1'b1; bus.program_selection = 3'b000; bus.start = 1'b1;
        push_phase(4'd2, 10, A_COLD);
        push_phase(4'd3, 20, A_MOT);
        push_phase(4'd4, 8, A_OUT);
        push_rinses_spin_done();
        while (sb.size() != 0) begin
            @(negedge clk);
            e = sb.pop_front(); o = obs(); n_vec++;
            if (o !== e) begin
                n_miss++;
                $display("FAIL cold_wash idx=%0d got ph=%0d disp=%0d act=%b want ph=%0d disp=%0d act=%b",
                         i, o.ph, o.disp, o.act, e.ph, e.disp, e.act);
            end
            if (bus.program_done && done_at < 0) done_at = i + 1;
            bus.start = 1'b0;
            i++;
        end
        n_vec++;
        if (done_at !== 117) begin
            n_miss++;
            $display("FAIL cold_done_cycle got %0d want 117", done_at);
        end
    endtask

    task automatic test_soap_wait();
        int i = 0;
        exp_t e, o;
        bus.soap = 1'b0; bus.program_selection = 3'b001; bus.start = 1'b1;
        for (int d = 50; d >= 21; d--) sb.push_back({4'd1, 8'(d), A_SW});
        for (int d = 10; d >= 8; d--) sb.push_back({4'd2, 8'(d), A_HOT});
        push_hold(4'd0, 0, 2, A_NONE);
        while (sb.size() != 0) begin
            @(negedge clk);
            e = sb.pop_front(); o = obs(); n_vec++;
            if (o !== e) begin
                n_miss++;
                $display("FAIL soap_wait idx=%0d got ph=%0d disp=%0d act=%b want ph=%0d disp=%0d act=%b",
                         i, o.ph, o.disp, o.act, e.ph, e.disp, e.act);
            end
            bus.start = 1'b0;
            if (i == 29) bus.soap = 1'b1;
            if (i == 32) bus.power = 1'b0;
            i++;
        end
        bus.power = 1'b1;
    endtask

    task automatic test_soap_timeout();
        int i = 0;
        exp_t e, o;
        bus.soap = 1'b0; bus.program_selection = 3'b000; bus.start = 1'b1;
        push_phase(4'd1, 50, A_SW);
        push_hold(4'd0, 0, 3, A_NONE);
        while (sb.size() != 0) begin
            @(negedge clk);
            e = sb.pop_front(); o = obs(); n_vec++;
            if (o !== e) begin
                n_miss++;
                $display("FAIL soap_timeout idx=%0d got ph=%0d disp=%0d act=%b want ph=%0d disp=%0d act=%b",
                         i, o.ph, o.disp, o.act, e.ph, e.disp, e.act);
            end
            bus.start = 1'b0;
            i++;
        end
    endtask

    task automatic test_pause_soap();
        int i = 0;
        exp_t e, o;
        bus.soap = 1'b0; bus.program_selection = 3'b001; bus.start = 1'b1;
        push_phase(4'd1, 50, A_SW);
        sb = sb[0:4];
        push_hold(4'd10, 46, 3, A_SW);
        push_hold(4'd1, 46, 1, A_SW);
        push_hold(4'd1, 45, 1, A_SW);
        push_hold(4'd0, 0, 2, A_NONE);
        while (sb.size() != 0) begin
            @(negedge clk);
            e = sb.pop_front(); o = obs(); n_vec++;
            if (o !== e) begin
                n_miss++;
                $display("FAIL pause_soap idx=%0d got ph=%0d disp=%0d act=%b want ph=%0d disp=%0d act=%b",
                         i, o.ph, o.disp, o.act, e.ph, e.disp, e.act);
            end
            bus.start = 1'b0;
            if (i == 4) bus.doorclosed = 1'b0;
            if (i == 7) bus.doorclosed = 1'b1;
            if (i == 9) bus.power = 1'b0;
            if (i == 10) bus.start = 1'b1;
            i++;
        end
        bus.power = 1'b1;
        bus.start = 1'b0;
        bus.soap  = 1'b1;
    endtask

    task automatic test_door_pause();
        int i = 0;
        exp_t e, o;
        bus.soap = 1'b1; bus.program_selection = 3'b000; bus.start = 1'b1;
        push_phase(4'd2, 10, A_COLD);
        for (int d = 20; d >= 12; d--) sb.push_back({4'd3, 8'(d), A_MOT});
        push_hold(4'd10, 12, 7, A_NONE);
        push_phase(4'd3, 12, A_MOT);
        push_phase(4'd4, 8, A_OUT);
        push_rinses_spin_done();
        while (sb.size() != 0) begin
            @(negedge clk);
            e = sb.pop_front(); o = obs(); n_vec++;
            if (o !== e) begin
                n_miss++;
                $display("FAIL door_pause idx=%0d got ph=%0d disp=%0d act=%b want ph=%0d disp=%0d act=%b",
                         i, o.ph, o.disp, o.act, e.ph, e.disp, e.act);
            end
            bus.start = 1'b0;
            if (i == 18) bus.doorclosed = 1'b0;
            if (i == 25) bus.doorclosed = 1'b1;
            i++;
        end
    endtask

    task automatic test_dry_and_invalid();
        int i = 0;
        exp_t e, o;
        bus.program_selection = 3'b011; bus.start = 1'b1;
        push_phase(4'd8, 12, A_SPIN);
        push_hold(4'd9, 0, 1, A_DONE);
        push_hold(4'd0, 0, 1, A_NONE);
        // Illegal code, then a legal code with the door open: both stay idle.
        push_hold(4'd0, 0, 3, A_NONE);
        push_hold(4'd0, 0, 3, A_NONE);
        while (sb.size() != 0) begin
            @(negedge clk);
            e = sb.pop_front(); o = obs(); n_vec++;
            if (o !== e) begin
                n_miss++;
                $display("FAIL dry_invalid idx=%0d got ph=%0d disp=%0d act=%b want ph=%0d disp=%0d act=%b",
                         i, o.ph, o.disp, o.act, e.ph, e.disp, e.act);
            end
            bus.start = 1'b0;
            if (i == 13) begin bus.program_selection = 3'b110; bus.start = 1'b1; end
            if (i == 16) begin bus.program_selection = 3'b000; bus.start = 1'b1; bus.doorclosed = 1'b0; end
            i++;
        end
        bus.doorclosed = 1'b1;
    endtask

    task automatic test_rinse_power();
        int i = 0;
        exp_t e, o;
        bus.soap = 1'b0; bus.program_selection = 3'b010; bus.start = 1'b1;
        push_rinses_spin_done();
        while (sb.size() != 0) begin
            @(negedge clk);
            e = sb.pop_front(); o = obs(); n_vec++;
            if (o !== e) begin
                n_miss++;
                $display("FAIL rinse_dry idx=%0d got ph=%0d disp=%0d act=%b want ph=%0d disp=%0d act=%b",
                         i, o.ph, o.disp, o.act, e.ph, e.disp, e.act);
            end
            bus.start = 1'b0;
            if (i == 15) begin bus.program_selection = 3'b011; bus.start = 1'b1; end
            i++;
        end
        i = 0;
        bus.program_selection = 3'b010; bus.start = 1'b1;
        push_phase(4'd5, 10, A_COLD);
        push_phase(4'd6, 15, A_MOT);
        push_phase(4'd7, 8, A_OUT);
        push_phase(4'd5, 10, A_COLD);
        for (int d = 15; d >= 10; d--) sb.push_back({4'd6, 8'(d), A_MOT});
        push_hold(4'd0, 0, 2, A_NONE);
        while (sb.size() != 0) begin
            @(negedge clk);
            e = sb.pop_front(); o = obs(); n_vec++;
            if (o !== e) begin
                n_miss++;
                $display("FAIL rinse_power idx=%0d got ph=%0d disp=%0d act=%b want ph=%0d disp=%0d act=%b",
                         i, o.ph, o.disp, o.act, e.ph, e.disp, e.act);
            end
            bus.start = 1'b0;
            if (i == 48) begin bus.power = 1'b0; bus.doorclosed = 1'b0; end
            i++;
        end
        bus.power = 1'b1; bus.doorclosed = 1'b1;
        // A fresh rinse program after the abort must run both rinses again.
        i = 0;
        bus.start = 1'b1;
        push_rinses_spin_done();
        while (sb.size() != 0) begin
            @(negedge clk);
            e = sb.pop_front(); o = obs(); n_vec++;
            if (o !== e) begin
                n_miss++;
                $display("FAIL rinse_fresh idx=%0d got ph=%0d disp=%0d act=%b want ph=%0d disp=%0d act=%b",
                         i, o.ph, o.disp, o.act, e.ph, e.disp, e.act);
            end
            bus.start = 1'b0;
            i++;
        end
    endtask

    task automatic test_reset_mid_spin();
        int i = 0;
        exp_t e, o;
        bus.program_selection = 3'b011; bus.start = 1'b1;
        for (int d = 12; d >= 7; d--) sb.push_back({4'd8, 8'(d), A_SPIN});
        while (sb.size() != 0) begin
            @(negedge clk);
            e = sb.pop_front(); o = obs(); n_vec++;
            if (o !== e) begin
                n_miss++;
                $display("FAIL mid_spin idx=%0d got ph=%0d disp=%0d act=%b want ph=%0d disp=%0d act=%b",
                         i, o.ph, o.disp, o.act, e.ph, e.disp, e.act);
            end
            bus.start = 1'b0;
            i++;
        end
        rst = 1'b1;
        #1;
        o = obs(); n_vec++;
        if (o !== exp_t'(0)) begin
            n_miss++;
            $display("FAIL async_reset got %h want 0", o);
        end
        @(negedge clk);
        rst = 1'b0;
        i = 0;
        push_hold(4'd0, 0, 3, A_NONE);
        while (sb.size() != 0) begin
            @(negedge clk);
            e = sb.pop_front(); o = obs(); n_vec++;
            if (o !== e) begin
                n_miss++;
                $display("FAIL no_resume idx=%0d got ph=%0d disp=%0d act=%b want ph=%0d disp=%0d act=%b",
                         i, o.ph, o.disp, o.act, e.ph, e.disp, e.act);
            end
            i++;
        end
        i = 0;
        bus.start = 1'b1;
        push_phase(4'd8, 12, A_SPIN);
        push_hold(4'd9, 0, 1, A_DONE);
        push_hold(4'd0, 0, 2, A_NONE);
        while (sb.size() != 0) begin
            @(negedge clk);
            e = sb.pop_front(); o = obs(); n_vec++;
            if (o !== e) begin
                n_miss++;
                $display("FAIL fresh_spin idx=%0d got ph=%0d disp=%0d act=%b want ph=%0d disp=%0d act=%b",
                         i, o.ph, o.disp, o.act, e.ph, e.disp, e.act);
            end
            bus.start = 1'b0;
            i++;
        end
    endtask

    initial begin
        bus.power             = 1'b1;
        bus.doorclosed        = 1'b1;
        bus.soap              = 1'b1;
        bus.start             = 1'b0;
        bus.program_selection = 3'b000;
        test_reset();
        test_cold_wash();
        test_soap_wait();
        test_soap_timeout();
        test_pause_soap();
        test_door_pause();
        test_dry_and_invalid();
        test_rinse_power();
        test_reset_mid_spin();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
